capture_sequencer: RTL and testbench

Controls sample capture into the codec double buffer in the bclk domain. It takes stereo sample-pair strobes from the I2S receiver and applies channel/mono selection and decimation. It issues one write strobe per kept sample, which drives the buffer's data-ready input. It sequences 1024-sample frames in single-shot or continuous mode and reports frame completion and overrun against the consumer's acknowledge.

---
 rtl/codec_pkg.sv | 19 +
 rtl/toggle_sync.sv | 31 +++
 rtl/capture_sequencer.sv | 148 ++++++++++++++
 tb/tb_capture_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared codec constants and encodings for the bclk-side
// capture path and its mclk-side consumers.
package codec_pkg;

  localparam int DATA_BITS = 16;
  localparam int FRAME_LEN = 1024;
  localparam int FRAME_AW  = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  localparam logic [1:0] MODE_L    = 2'b00;
  localparam logic [1:0] MODE_R    = 2'b01;
  localparam logic [1:0] MODE_MONO = 2'b10;

endpackage

// File: rtl/toggle_sync.sv
// Toggle-to-pulse crossing: 2-FF synchronizer, edge detect,
// registered one-cycle pulse in the destination domain.
module toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_i,
  output logic pulse_o
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= tgl_i;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_pulse <= r_s2 ^ r_prev;
    end
  end

  assign pulse_o = r_pulse;

endmodule

// File: rtl/capture_sequencer.sv
// Sample capture sequencer: channel select, decimation and
// frame sequencing into the codec double buffer (bclk domain).
module capture_sequencer #(
  parameter int DATA_BITS  = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int DECIM_BITS = 4
) (
  input  logic                  bclk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_mode_i,
  input  logic [DECIM_BITS-1:0] cfg_decim_i,
  input  logic                  cfg_single_i,
  input  logic                  arm_i,
  input  logic                  stop_i,
  input  logic                  i2s_valid_i,
  input  logic [DATA_BITS-1:0]  i2s_l_i,
  input  logic [DATA_BITS-1:0]  i2s_r_i,
  input  logic                  frame_ack_tgl_i,
  output logic                  wr_valid_o,
  output logic [DATA_BITS-1:0]  wr_data_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [1:0]            state_o
);

  import codec_pkg::*;

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  state_e                r_state;
  logic [1:0]            r_mode;
  logic [DECIM_BITS-1:0] r_decim;
  logic [DECIM_BITS-1:0] r_dec_cnt;
  logic                  r_single;
  logic [AW-1:0]         r_cnt;
  logic                  r_stop_pend;
  logic                  r_pend;
  logic                  r_ovr;
  logic                  r_wr_valid;
  logic [DATA_BITS-1:0]  r_wr_data;
  logic                  r_done;

  logic                  w_ack;
  logic                  w_cap;
  logic                  w_keep;
  logic                  w_last;
  logic [DATA_BITS:0]    w_sum;
  logic [DATA_BITS-1:0]  w_sel;

  toggle_sync u_ack_sync (
    .clk     (bclk),
    .rst_n   (rst_n),
    .tgl_i   (frame_ack_tgl_i),
    .pulse_o (w_ack)
  );

  assign w_cap  = (r_state == ST_CAPTURE) && i2s_valid_i;
  assign w_keep = w_cap && (r_dec_cnt == '0);
  assign w_last = w_keep && (r_cnt == LAST);

  // Floor average: drop the LSB of the 17-bit signed sum.
  assign w_sum = {i2s_l_i[DATA_BITS-1], i2s_l_i}
               + {i2s_r_i[DATA_BITS-1], i2s_r_i};

  always_comb begin
    w_sel = i2s_l_i;
    case (r_mode)
      MODE_R:    w_sel = i2s_r_i;
      MODE_MONO: w_sel = w_sum[DATA_BITS:1];
      default:   w_sel = i2s_l_i;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_decim     <= '0;
      r_dec_cnt   <= '0;
      r_single    <= 1'b0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_pend      <= 1'b0;
      r_ovr       <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_wr_valid <= w_keep;
      r_done     <= w_last;
      if (w_keep) begin
        r_wr_data <= w_sel;
        r_cnt     <= r_cnt + 1'b1;
      end
      if (w_cap)
        r_dec_cnt <= w_keep ? r_decim : r_dec_cnt - 1'b1;
      // A coincident ack retires the old frame before the new one lands.
      if (r_done) begin
        if (r_pend && !w_ack)
          r_ovr <= 1'b1;
        r_pend <= 1'b1;
      end else if (w_ack) begin
        r_pend <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (arm_i && !stop_i) begin
            r_state     <= ST_CAPTURE;
            r_mode      <= cfg_mode_i;
            r_decim     <= cfg_decim_i;
            r_single    <= cfg_single_i;
            r_cnt       <= '0;
            r_dec_cnt   <= '0;
            r_ovr       <= 1'b0;
            r_pend      <= 1'b0;
            r_stop_pend <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (stop_i)
            r_stop_pend <= 1'b1;
          // Leave only on a frame boundary to keep writes frame-aligned.
          if (r_done) begin
            if (r_stop_pend || stop_i)
              r_state <= ST_IDLE;
            else if (r_single)
              r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_ack || stop_i)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_valid_o   = r_wr_valid;
  assign wr_data_o    = r_wr_data;
  assign frame_done_o = r_done;
  assign busy_o       = (r_state != ST_IDLE);
  assign overrun_o    = r_ovr;
  assign state_o      = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: channel modes,
// decimation, frame sequencing, stop, ack and overrun.
module tb_capture_sequencer;

  logic        bclk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_mode_i;
  logic [3:0]  cfg_decim_i;
  logic        cfg_single_i;
  logic        arm_i;
  logic        stop_i;
  logic        i2s_valid_i;
  logic [15:0] i2s_l_i;
  logic [15:0] i2s_r_i;
  logic        frame_ack_tgl_i;
  logic        wr_valid_o;
  logic [15:0] wr_data_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        overrun_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;
  logic        s_v;
  logic [15:0] s_d;
  logic        s_f;
  int writes;
  int frames;

  capture_sequencer dut (
    .bclk            (bclk),
    .rst_n           (rst_n),
    .cfg_mode_i      (cfg_mode_i),
    .cfg_decim_i     (cfg_decim_i),
    .cfg_single_i    (cfg_single_i),
    .arm_i           (arm_i),
    .stop_i          (stop_i),
    .i2s_valid_i     (i2s_valid_i),
    .i2s_l_i         (i2s_l_i),
    .i2s_r_i         (i2s_r_i),
    .frame_ack_tgl_i (frame_ack_tgl_i),
    .wr_valid_o      (wr_valid_o),
    .wr_data_o       (wr_data_o),
    .frame_done_o    (frame_done_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o),
    .state_o         (state_o)
  );

  always #5 bclk = ~bclk;

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Valid cycle only; outputs sampled right after the edge.
  task automatic vtick(input logic [15:0] l, input logic [15:0] r);
    i2s_valid_i = 1'b1;
    i2s_l_i     = l;
    i2s_r_i     = r;
    tick();
    i2s_valid_i = 1'b0;
    s_v = wr_valid_o;
    s_d = wr_data_o;
    s_f = frame_done_o;
  endtask

  task automatic pair(input logic [15:0] l, input logic [15:0] r);
    vtick(l, r);
    tick();
  endtask

  task automatic arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    tick();
  endtask

  task automatic frame(input logic ack_late);
    frames = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ack_late && i == 1022)
        frame_ack_tgl_i = ~frame_ack_tgl_i;
      pair(16'(i), 16'h7FFF);
      frames += int'(s_f);
    end
    chk("frame_done_cnt", 32'(frames), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_mode_i = 2'b00;
    cfg_decim_i = 4'd0;
    cfg_single_i = 1'b0;
    arm_i = 1'b0;
    stop_i = 1'b0;
    i2s_valid_i = 1'b0;
    i2s_l_i = '0;
    i2s_r_i = '0;
    frame_ack_tgl_i = 1'b0;
    repeat (3) tick();
    chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    chk("rst_wr_data", 32'(wr_data_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // arm with a coincident pair: pair is not captured
    arm_i = 1'b1;
    i2s_valid_i = 1'b1;
    i2s_l_i = 16'hAAAA;
    tick();
    arm_i = 1'b0;
    i2s_valid_i = 1'b0;
    chk("arm_state", 32'(state_o), 32'd1);
    chk("arm_valid_nocap", 32'(wr_valid_o), 32'd0);
    tick();

    // mode L, decim 0, continuous frame
    for (int i = 0; i < 1024; i++) begin
      vtick(16'(i), 16'h7FFF);
      chk("L_valid", 32'(s_v), 32'd1);
      chk("L_data", 32'(s_d), 32'(i));
      chk("L_done", 32'(s_f), 32'(i == 1023));
      chk("L_busy", 32'(busy_o), 32'd1);
      tick();
      if (i == 0)
        chk("L_gap_novalid", 32'(wr_valid_o), 32'd0);
    end
    chk("L_cont_state", 32'(state_o), 32'd1);

    // reset at sample 300 of the next frame
    for (int i = 0; i < 300; i++)
      pair(16'(i), 16'h0);
    rst_n = 1'b0;
    vtick(16'h1234, 16'h0);
    chk("midrst_valid", 32'(s_v), 32'd0);
    chk("midrst_data", 32'(s_d), 32'd0);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // mono; config change after arm is ignored
    cfg_mode_i = 2'b10;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    cfg_mode_i = 2'b00;
    tick();
    pair(16'h7FFF, 16'h7FFF);
    chk("mono_max", 32'(s_d), 32'h7FFF);
    pair(16'h8000, 16'h8000);
    chk("mono_min", 32'(s_d), 32'h8000);
    pair(16'h0001, 16'hFFFE);
    chk("mono_floor", 32'(s_d), 32'hFFFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // mode R quick check
    cfg_mode_i = 2'b01;
    arm();
    pair(16'h1111, 16'h2222);
    chk("R_data", 32'(s_d), 32'h2222);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // decim 3: keep pairs 0,4,8,...
    cfg_mode_i = 2'b00;
    cfg_decim_i = 4'd3;
    arm();
    writes = 0;
    frames = 0;
    for (int i = 0; i < 4096; i++) begin
      pair(16'(i), 16'h0);
      chk("dec_valid", 32'(s_v), 32'(i % 4 == 0));
      if (s_v)
        chk("dec_data", 32'(s_d), 32'(i));
      writes += int'(s_v);
      frames += int'(s_f);
    end
    chk("dec_writes", 32'(writes), 32'd1024);
    chk("dec_frames", 32'(frames), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cfg_decim_i = 4'd0;

    // stop at sample 500 runs the frame out
    arm();
    for (int i = 0; i < 500; i++)
      pair(16'(i), 16'h0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("stop_still_cap", 32'(state_o), 32'd1);
    for (int i = 500; i < 1024; i++) begin
      pair(16'(i), 16'h0);
      if (i == 700)
        chk("stop_data", 32'(s_d), 32'd700);
    end
    chk("stop_done", 32'(s_f), 32'd1);
    chk("stop_idle", 32'(state_o), 32'd0);
    chk("stop_busy", 32'(busy_o), 32'd0);
    pair(16'h5555, 16'h0);
    chk("idle_nowrite", 32'(s_v), 32'd0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("idle_stop", 32'(state_o), 32'd0);
    arm_i = 1'b1;
    stop_i = 1'b1;
    tick();
    arm_i = 1'b0;
    stop_i = 1'b0;
    chk("arm_stop_idle", 32'(state_o), 32'd0);

    // single-shot to DONE, then ack back to IDLE
    cfg_single_i = 1'b1;
    arm();
    frame(1'b0);
    chk("ss_done_state", 32'(state_o), 32'd2);
    pair(16'h4242, 16'h0);
    chk("ss_nowrite", 32'(s_v), 32'd0);
    frame_ack_tgl_i = ~frame_ack_tgl_i;
    repeat (3) tick();
    chk("ss_wait_ack", 32'(state_o), 32'd2);
    tick();
    chk("ss_ack_idle", 32'(state_o), 32'd0);

    // continuous, ack withheld for two frames
    cfg_single_i = 1'b0;
    arm();
    frame(1'b0);
    chk("ovr_f1", 32'(overrun_o), 32'd0);
    for (int i = 0; i < 1023; i++)
      pair(16'(i), 16'h0);
    vtick(16'h03FF, 16'h0);
    chk("ovr_f2_done", 32'(s_f), 32'd1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("ovr_set", 32'(overrun_o), 32'd1);
    chk("stop_at_done_idle", 32'(state_o), 32'd0);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("arm_clr_ovr", 32'(overrun_o), 32'd0);
    tick();

    // ack lands with frame_done: no overrun
    frame(1'b0);
    frame(1'b1);
    chk("ack_same_cycle", 32'(overrun_o), 32'd0);
    chk("ack_still_cap", 32'(state_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
